level_latch: RTL and testbench
==============================

Name: level_latch

Overview:
- Parameterised, level-sensitive D latch bank with an asynchronous active-low reset.
- While io_clk is high the latch is transparent and io_q follows io_d combinationally. While io_clk is low, io_q holds the value present when io_clk fell.
- Used as a storage primitive in generated scan/config chains, where a latch is preferred over a flop.
- Built from WIDTH identical single-bit latch cells.

Parameters:
- WIDTH, 8, data width of io_d/io_q in bits.
- RESET_VALUE, {WIDTH{1'b0}}, value forced onto io_q while reset is asserted.
- TRANSPARENT_HIGH, 1, 1 = transparent while io_clk high; 0 = transparent while io_clk low (io_clk inverted internally).

Ports:
- io_clk  input  1  latch enable (gate); the single clock of the block.
- io_rst_n  input  1  asynchronous active-low reset.
- io_d  input  WIDTH  data in.
- io_q  output  WIDTH  latched data out.

Behaviour:
- One clock (io_clk); reset is asynchronous and active-low (io_rst_n). Reset is not synchronised inside the block.
- Reset:
  - io_rst_n=0 forces io_q=RESET_VALUE immediately, regardless of io_clk or io_d.
  - Reset overrides transparency.
- Transparent phase (io_rst_n=1, io_clk=1 with default polarity):
  - io_q = io_d with zero-cycle latency, no added delay.
  - Every change on io_d propagates to io_q within the same time step.
- Opaque phase (io_clk=0):
  - io_q holds the io_d value present at the closing edge of io_clk.
  - Changes on io_d are ignored, including glitches and any number of changes.
- Closing edge: io_d must be stable across the falling edge of io_clk.
  - If io_d and io_clk change in the same time step, the captured value is the io_d value from before that time step.
  - Example: d=0 held, then clk 1→0 and d 0→1 together gives q=0.
- Reset release:
  - io_clk high at release: io_q takes io_d immediately.
  - io_clk low at release: io_q keeps RESET_VALUE until the next transparent phase.
- Width rules: all bits are independent, with identical behaviour per bit. No arithmetic.
- Power-up without reset: io_q is X until the first transparent phase or reset. The bench must not rely on it.
- Implementation style:
  - Inferred latch: always_latch or equivalent, with reset in the sensitivity. No clock gating cells.
  - Lint waivers for intentional latch inference are allowed.

Decomposition:
- Shared package: default WIDTH constant and a RESET_VALUE default constant for the scan-chain family. No typedefs are needed.
- One sub-module, latch_cell: 1-bit transparent latch with async active-low reset and a reset-value input. level_latch instantiates WIDTH copies in a generate loop and applies the TRANSPARENT_HIGH polarity inversion.

Test Plan:
1. Reset: io_rst_n=0, io_clk=1, io_d=8'hFF → io_q=8'h00 immediately. Then release reset with io_clk=1 → io_q=8'hFF.
2. Transparency: io_clk=1, io_d=8'h01 → io_q=8'h01 after #1. Then io_d=8'h00 → io_q=8'h00 after #1.
3. Hold:
   - io_clk=1 with io_d=8'h00, then io_clk→0 and io_d=8'h01 in the same step → io_q=8'h00 after #1.
   - Then io_d=8'h00 → io_q stays 8'h00.
   - Then io_d toggled for 100 ns → io_q unchanged.
4. Capture non-zero: io_clk=1, io_d=8'hA5, io_clk→0, then io_d=8'h5A → io_q=8'hA5. Reopen with io_clk=1 → io_q=8'h5A.
5. Reset mid-hold: io_clk=0 with io_q=8'hA5, assert io_rst_n=0 → io_q=8'h00 with no clock edge. Release with io_clk=0 → io_q remains 8'h00.
6. Polarity: TRANSPARENT_HIGH=0, io_clk=0, io_d=8'h3C → io_q=8'h3C. Then io_clk=1 and io_d=8'hC3 → io_q=8'h3C.

Source files
------------

// File: rtl/level_latch_pkg.sv
// Shared constants for the scan/config-chain latch family.
package level_latch_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

endpackage : level_latch_pkg

// File: rtl/level_latch_cell.sv
// Single-bit transparent latch with asynchronous active-low reset to a supplied value.
module latch_cell (
  input  logic en,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  // Reset dominates; otherwise transparent while en is high, holding while low.
  always_latch begin
    if (!rst_n) begin
      q <= rst_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : latch_cell

// File: rtl/level_latch.sv
// Parameterised level-sensitive latch bank built from WIDTH independent latch cells.
module level_latch
  import level_latch_pkg::*;
#(
  parameter int unsigned            WIDTH            = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]       RESET_VALUE      = WIDTH'(DEFAULT_RESET_VALUE),
  parameter bit                     TRANSPARENT_HIGH = 1'b1
) (
  input  logic             io_clk,
  input  logic             io_rst_n,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q
);

  logic en;

  // Gate polarity is fixed at elaboration; low-transparent banks see an inverted gate.
  generate
    if (TRANSPARENT_HIGH) begin : g_en_high
      assign en = io_clk;
    end else begin : g_en_low
      assign en = ~io_clk;
    end
  endgenerate

  generate
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
      latch_cell u_cell (
        .en      (en),
        .rst_n   (io_rst_n),
        .rst_val (RESET_VALUE[i]),
        .d       (io_d[i]),
        .q       (io_q[i])
      );
    end
  endgenerate

endmodule : level_latch

// File: tb/tb_level_latch.sv
// Directed-vector bench for level_latch: high- and low-transparent instances.
module tb_level_latch;

  logic       clk_h, rst_n_h;
  logic [7:0] d_h, q_h;
  logic       clk_l, rst_n_l;
  logic [7:0] d_l, q_l;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  level_latch #(
    .WIDTH            (8),
    .RESET_VALUE      (8'h00),
    .TRANSPARENT_HIGH (1'b1)
  ) u_dut_h (
    .io_clk   (clk_h),
    .io_rst_n (rst_n_h),
    .io_d     (d_h),
    .io_q     (q_h)
  );

  level_latch #(
    .WIDTH            (8),
    .RESET_VALUE      (8'h96),
    .TRANSPARENT_HIGH (1'b0)
  ) u_dut_l (
    .io_clk   (clk_l),
    .io_rst_n (rst_n_l),
    .io_d     (d_l),
    .io_q     (q_l)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk_h = 1'b1; rst_n_h = 1'b0; d_h = 8'hFF;
    clk_l = 1'b1; rst_n_l = 1'b0; d_l = 8'h00;

    // Reset with gate open, then release while transparent
    #1 check("rst_open", q_h, 8'h00);
    d_h = 8'h3F;
    #1 check("rst_dominates_d", q_h, 8'h00);
    d_h = 8'hFF;
    rst_n_h = 1'b1;
    #1 check("rel_open", q_h, 8'hFF);

    // Transparency
    d_h = 8'h01;
    #1 check("transp_01", q_h, 8'h01);
    d_h = 8'h00;
    #1 check("transp_00", q_h, 8'h00);

    // Gate closes in the same step as d changes: old d is captured
    clk_h = 1'b0;
    d_h   = 8'h01;
    #1 check("close_race", q_h, 8'h00);
    d_h = 8'h00;
    #1 check("hold_d00", q_h, 8'h00);
    for (int i = 0; i < 20; i++) begin
      d_h = (i % 2 == 0) ? 8'hFF : 8'h5A;
      #5;
    end
    check("hold_toggle", q_h, 8'h00);

    // Capture a non-zero value and reopen
    clk_h = 1'b1;
    d_h   = 8'hA5;
    #1 check("open_a5", q_h, 8'hA5);
    clk_h = 1'b0;
    #1 d_h = 8'h5A;
    #1 check("hold_a5", q_h, 8'hA5);
    clk_h = 1'b1;
    #1 check("reopen_5a", q_h, 8'h5A);

    // Reset during hold, release while gate closed
    d_h = 8'hA5;
    #1 clk_h = 1'b0;
    #1 check("pre_rst_hold", q_h, 8'hA5);
    rst_n_h = 1'b0;
    #1 check("rst_in_hold", q_h, 8'h00);
    rst_n_h = 1'b1;
    #1 check("rel_closed", q_h, 8'h00);
    d_h = 8'h77;
    #1 check("rel_closed_d", q_h, 8'h00);
    clk_h = 1'b1;
    #1 check("after_rel_open", q_h, 8'h77);

    // Low-transparent instance: reset value, then polarity behaviour
    #1 check("lo_rst", q_l, 8'h96);
    rst_n_l = 1'b1;
    #1 check("lo_rel_closed", q_l, 8'h96);
    clk_l = 1'b0;
    d_l   = 8'h3C;
    #1 check("lo_transp", q_l, 8'h3C);
    clk_l = 1'b1;
    d_l   = 8'hC3;
    #1 check("lo_hold", q_l, 8'h3C);
    clk_l = 1'b0;
    #1 check("lo_reopen", q_l, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_level_latch
